// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide engine shared by MULT, MULTU, DIV and DIVU.
// Signed operations work on operand magnitudes: the result signs are recorded
// when the operation is accepted and applied once, in the FIX cycle.
// Multiply is radix-2 shift-add. Divide is restoring. Both take WIDTH steps.
//
// Ports
//   clock_i     system clock, rising-edge active
//   reset_i     synchronous active-low reset
//   start_i     operation request, sampled only while idle
//   op_i        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i         multiplicand / dividend
//   b_i         multiplier / divisor
//   busy_o      operation in flight (RUN or FIX)
//   done_o      one-cycle pulse, hi_o/lo_o valid from this cycle on
//   div_zero_o  divide by zero seen, held until the next accepted start
//   hi_o        product upper half / remainder
//   lo_o        product lower half / quotient
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]        CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               opDiv_q;
    logic               resNeg_q;
    logic               remNeg_q;
    logic               dzPend_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               busy_q;
    logic               done_q;
    logic               divZero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand decode at acceptance time. op_i[0] = 0 selects a signed
    // operation, op_i[1] = 1 selects divide.
    logic               startSigned;
    logic               startDiv;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aAbs;
    logic [WIDTH-1:0]   bAbs;
    logic               bZero;

    assign startSigned = ~op_i[0];
    assign startDiv    = op_i[1];
    assign aNeg        = startSigned & a_i[WIDTH-1];
    assign bNeg        = startSigned & b_i[WIDTH-1];
    assign aAbs        = aNeg ? (~a_i + ONE_W) : a_i;
    assign bAbs        = bNeg ? (~b_i + ONE_W) : b_i;
    assign bZero       = (b_i == '0);

    // Multiply step. The accumulator holds {upper, multiplier}. The addition
    // produces a WIDTH+1 bit sum, which forms the 2W+1 bit accumulator before
    // the right shift. The shift drops the consumed multiplier bit and keeps
    // the carry in the result.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;

    assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

    // Divide step. The accumulator holds {rem, quo}. The shifted remainder
    // needs WIDTH+1 bits, and one more bit is needed for the trial sign. A
    // restored remainder is always below the divisor, so it fits back into
    // WIDTH bits.
    logic [WIDTH:0]     remShift;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] divNext;

    assign remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = {1'b0, remShift} - {2'b00, opnd_q};
    assign divNext  = trial[WIDTH+1]
                    ? {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {trial[WIDTH-1:0],    acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] acc_d;
    assign acc_d = opDiv_q ? divNext : mulNext;

    // Sign fix-up applied in FIX. The remainder takes the dividend sign, so
    // the quotient truncates toward zero. For MIN / -1 the quotient negation
    // wraps back to MIN.
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoRaw;
    logic [WIDTH-1:0]   remRaw;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    assign prodFix = resNeg_q ? (~acc_q + ONE_2W) : acc_q;
    assign quoRaw  = acc_q[WIDTH-1:0];
    assign remRaw  = acc_q[2*WIDTH-1:WIDTH];
    assign quoFix  = resNeg_q ? (~quoRaw + ONE_W) : quoRaw;
    assign remFix  = remNeg_q ? (~remRaw + ONE_W) : remRaw;
    assign hi_d    = opDiv_q ? remFix : prodFix[2*WIDTH-1:WIDTH];
    assign lo_d    = opDiv_q ? quoFix : prodFix[WIDTH-1:0];

    // Control FSM and datapath registers. All outputs are registered.
    // On a divide by zero, dzPend_q routes the operation straight to FIX.
    // In that case FIX reports the error and leaves hi/lo untouched.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            opDiv_q   <= 1'b0;
            resNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            dzPend_q  <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        opDiv_q   <= startDiv;
                        opnd_q    <= startDiv ? bAbs : aAbs;
                        acc_q     <= {{WIDTH{1'b0}}, (startDiv ? aAbs : bAbs)};
                        resNeg_q  <= aNeg ^ bNeg;
                        remNeg_q  <= aNeg;
                        cnt_q     <= CNT_INIT;
                        divZero_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (startDiv && bZero) begin
                            dzPend_q <= 1'b1;
                            state_q  <= FIX;
                        end else begin
                            dzPend_q <= 1'b0;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (dzPend_q) begin
                        divZero_q <= 1'b1;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = divZero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit. It instantiates two copies of the unit:
// one with WIDTH=32 and one with WIDTH=8. Inputs change half a cycle before
// the active edge. Outputs are sampled 1 time unit after the active edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;

   logic        start32 = 1'b0;
   logic [1:0]  op32 = 2'b00;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        busy32;
   logic        done32;
   logic        divZero32;
   logic [31:0] hi32;
   logic [31:0] lo32;

   logic        start8 = 1'b0;
   logic [1:0]  op8 = 2'b00;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8;
   logic        done8;
   logic        divZero8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;

   int checks = 0;
   int errors = 0;

   // Free-running clock with a period of 10 time units.
   always #5 clock = ~clock;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clock_i(clock), .reset_i(resetN), .start_i(start32), .op_i(op32),
      .a_i(a32), .b_i(b32), .busy_o(busy32), .done_o(done32),
      .div_zero_o(divZero32), .hi_o(hi32), .lo_o(lo32)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clock_i(clock), .reset_i(resetN), .start_i(start8), .op_i(op8),
      .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8),
      .div_zero_o(divZero8), .hi_o(hi8), .lo_o(lo8)
   );

   // Hard stop in case a task ever loses track of the clock.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Starts an operation on the 32-bit unit. The task returns 1 time unit
   // after the accepting edge. The operands are then scrambled, so any
   // dependence on the live inputs shows up in the result.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      start32 = 1'b1;
      op32 = op;
      a32 = a;
      b32 = b;
      @(posedge clock);
      #1;
      start32 = 1'b0;
      a32 = $urandom;
      b32 = $urandom;
      op32 = 2'($urandom_range(0, 3));
   endtask

   // Starts an operation on the 8-bit unit.
   task automatic applyStimulus8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clock);
      start8 = 1'b1;
      op8 = op;
      a8 = a;
      b8 = b;
      @(posedge clock);
      #1;
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
   endtask

   // Counts the edges from the accepting edge to done. The bound is 100
   // edges; a timeout leaves the cycle count wrong, and the caller's check
   // then fails. busyCycles counts the sampled cycles with busy high,
   // starting with the sample taken just after the accepting edge.
   task automatic waitDone32(output int cycles, output int busyCycles);
      cycles = 0;
      busyCycles = busy32 ? 1 : 0;
      while (!done32 && cycles < 100) begin
         @(posedge clock);
         #1;
         cycles++;
         if (busy32) busyCycles++;
      end
   endtask

   task automatic waitDone8(output int cycles);
      cycles = 0;
      while (!done8 && cycles < 100) begin
         @(posedge clock);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy32, done32, divZero32} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags32: got %b expected 000", {busy32, done32, divZero32});
      end
      checks++;
      if ({hi32, lo32} !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_hilo32: got %h expected 0", {hi32, lo32});
      end
      checks++;
      if ({busy8, done8, divZero8, hi8, lo8} !== 19'h0) begin
         errors++;
         $display("[TB] FAIL reset_all8: got %h expected 0", {busy8, done8, divZero8, hi8, lo8});
      end
      resetN = 1'b1;
   endtask

   task automatic test_mult();
      int cycles, busyCycles;
      applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33) begin
         errors++;
         $display("[TB] FAIL mult_latency: got %0d expected 33", cycles);
      end
      checks++;
      if (busyCycles !== 33) begin
         errors++;
         $display("[TB] FAIL mult_busy: got %0d expected 33", busyCycles);
      end
      checks++;
      if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFEB) begin
         errors++;
         $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", hi32, lo32);
      end
      @(posedge clock);
      #1;
      checks++;
      if (done32 !== 1'b0 || hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFEB) begin
         errors++;
         $display("[TB] FAIL mult_pulse_hold: got done=%b %h_%h expected done=0 ffffffff_ffffffeb", done32, hi32, lo32);
      end
   endtask

   task automatic test_multu();
      int cycles, busyCycles;
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || hi32 !== 32'hFFFF_FFFE || lo32 !== 32'h0000_0001) begin
         errors++;
         $display("[TB] FAIL multu_max: got %0d cyc %h_%h expected 33 cyc fffffffe_00000001", cycles, hi32, lo32);
      end
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || hi32 !== 32'h0 || lo32 !== 32'h1) begin
         errors++;
         $display("[TB] FAIL mult_neg1sq: got %0d cyc %h_%h expected 33 cyc 00000000_00000001", cycles, hi32, lo32);
      end
   endtask

   task automatic test_div();
      int cycles, busyCycles;
      applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || lo32 !== 32'hFFFF_FFFD || hi32 !== 32'hFFFF_FFFF) begin
         errors++;
         $display("[TB] FAIL div_neg7by2: got %0d cyc q=%h r=%h expected 33 cyc q=fffffffd r=ffffffff", cycles, lo32, hi32);
      end
      checks++;
      if (divZero32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL div_nozero_flag: got %b expected 0", divZero32);
      end
      applyStimulus(2'b11, 32'd100, 32'd7);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || lo32 !== 32'd14 || hi32 !== 32'd2) begin
         errors++;
         $display("[TB] FAIL divu_100by7: got %0d cyc q=%h r=%h expected 33 cyc q=e r=2", cycles, lo32, hi32);
      end
      applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || lo32 !== 32'h8000_0000 || hi32 !== 32'h0) begin
         errors++;
         $display("[TB] FAIL div_min_by_neg1: got %0d cyc q=%h r=%h expected 33 cyc q=80000000 r=0", cycles, lo32, hi32);
      end
   endtask

   task automatic test_div_zero();
      int cycles, busyCycles;
      applyStimulus(2'b11, 32'd100, 32'd7);
      waitDone32(cycles, busyCycles);
      applyStimulus(2'b11, 32'd100, 32'd0);
      checks++;
      if (busy32 !== 1'b1 || done32 !== 1'b0 || divZero32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dz_accept: got busy=%b done=%b dz=%b expected 1 0 0", busy32, done32, divZero32);
      end
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 1 || divZero32 !== 1'b1 || busy32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dz_done: got %0d cyc dz=%b busy=%b expected 1 cyc dz=1 busy=0", cycles, divZero32, busy32);
      end
      checks++;
      if (hi32 !== 32'd2 || lo32 !== 32'd14) begin
         errors++;
         $display("[TB] FAIL dz_hold_hilo: got %h_%h expected 00000002_0000000e", hi32, lo32);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (divZero32 !== 1'b1 || done32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dz_sticky: got dz=%b done=%b expected dz=1 done=0", divZero32, done32);
      end
      applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd3);
      checks++;
      if (divZero32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL dz_clear_on_start: got %b expected 0", divZero32);
      end
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || hi32 !== 32'd2 || lo32 !== 32'hFFFF_FFFD) begin
         errors++;
         $display("[TB] FAIL dz_followup: got %0d cyc %h_%h expected 33 cyc 00000002_fffffffd", cycles, hi32, lo32);
      end
   endtask

   task automatic test_ignore_start();
      int cycles;
      applyStimulus(2'b01, 32'd3, 32'd4);
      cycles = 0;
      while (!done32 && cycles < 100) begin
         if (cycles == 4) begin
            start32 = 1'b1;
            op32 = 2'b11;
            a32 = 32'd100;
            b32 = 32'd7;
         end
         @(posedge clock);
         #1;
         cycles++;
         start32 = 1'b0;
      end
      checks++;
      if (cycles !== 33 || hi32 !== 32'd0 || lo32 !== 32'd12) begin
         errors++;
         $display("[TB] FAIL busy_start_ignored: got %0d cyc %h_%h expected 33 cyc 00000000_0000000c", cycles, hi32, lo32);
      end
   endtask

   task automatic test_abort();
      int cycles, busyCycles, spurious;
      applyStimulus(2'b00, 32'd5, 32'd6);
      repeat (9) @(posedge clock);
      #1;
      start32 = 1'b1;
      op32 = 2'b11;
      a32 = 32'd50;
      b32 = 32'd3;
      @(posedge clock);
      #1;
      start32 = 1'b0;
      checks++;
      if (busy32 !== 1'b1 || done32 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_midrun: got busy=%b done=%b expected 1 0", busy32, done32);
      end
      repeat (9) @(posedge clock);
      #1;
      resetN = 1'b0;
      @(posedge clock);
      #1;
      resetN = 1'b1;
      checks++;
      if ({busy32, done32, divZero32, hi32, lo32} !== 67'h0) begin
         errors++;
         $display("[TB] FAIL abort_reset_outputs: got busy=%b done=%b dz=%b %h_%h expected all 0", busy32, done32, divZero32, hi32, lo32);
      end
      spurious = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done32 || busy32) spurious++;
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", spurious);
      end
      applyStimulus(2'b00, 32'd5, 32'd6);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || hi32 !== 32'd0 || lo32 !== 32'd30) begin
         errors++;
         $display("[TB] FAIL abort_fresh_start: got %0d cyc %h_%h expected 33 cyc 00000000_0000001e", cycles, hi32, lo32);
      end
   endtask

   task automatic test_back_to_back();
      int cycles, busyCycles;
      applyStimulus(2'b01, 32'd3, 32'd4);
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles !== 33 || lo32 !== 32'd12) begin
         errors++;
         $display("[TB] FAIL b2b_first: got %0d cyc lo=%h expected 33 cyc lo=c", cycles, lo32);
      end
      applyStimulus(2'b11, 32'd100, 32'd7);
      checks++;
      if (busy32 !== 1'b1 || done32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd12) begin
         errors++;
         $display("[TB] FAIL b2b_accept: got busy=%b done=%b %h_%h expected 1 0 00000000_0000000c", busy32, done32, hi32, lo32);
      end
      waitDone32(cycles, busyCycles);
      checks++;
      if (cycles + 1 !== 34 || hi32 !== 32'd2 || lo32 !== 32'd14) begin
         errors++;
         $display("[TB] FAIL b2b_second: got %0d edges since done %h_%h expected 34 00000002_0000000e", cycles + 1, hi32, lo32);
      end
   endtask

   task automatic test_width8();
      int cycles;
      applyStimulus8(2'b00, 8'h80, 8'h80);
      waitDone8(cycles);
      checks++;
      if (cycles !== 9 || hi8 !== 8'h40 || lo8 !== 8'h00) begin
         errors++;
         $display("[TB] FAIL w8_mult_min: got %0d cyc %h_%h expected 9 cyc 40_00", cycles, hi8, lo8);
      end
      applyStimulus8(2'b01, 8'hFF, 8'hFF);
      waitDone8(cycles);
      checks++;
      if (cycles + 1 !== 10 || hi8 !== 8'hFE || lo8 !== 8'h01) begin
         errors++;
         $display("[TB] FAIL w8_b2b_multu: got %0d edges since done %h_%h expected 10 fe_01", cycles + 1, hi8, lo8);
      end
      applyStimulus8(2'b10, 8'hF9, 8'h02);
      waitDone8(cycles);
      checks++;
      if (cycles !== 9 || lo8 !== 8'hFD || hi8 !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL w8_div: got %0d cyc q=%h r=%h expected 9 cyc q=fd r=ff", cycles, lo8, hi8);
      end
   endtask

   // Runs the scenarios in sequence, then prints the summary line.
   initial begin
      $display("[TB] starting muldiv_unit bench");
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_width8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
